// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage hold/flush/forward controls out.
// The master side is the hazard controller; the slave side is the pipeline datapath.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1, id_rs2;
   logic             id_use_rs1, id_use_rs2;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic             ex_regwe, ex_load, ex_redirect;
   logic [4:0]       mem_rd, wb_rd;
   logic             mem_regwe, wb_regwe;
   logic             mem_req, mem_ack;

   logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
   logic             ifid_flush, idex_flush, memwb_bubble;
   logic [1:0]       fwd_a, fwd_b;
   logic             timeout_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic [1:0]       state_o;

   modport master (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_rs1, ex_rs2, ex_rd, ex_regwe, ex_load, ex_redirect,
      input  mem_rd, wb_rd, mem_regwe, wb_regwe, mem_req, mem_ack,
      output pc_hold, ifid_hold, idex_hold, exmem_hold,
      output ifid_flush, idex_flush, memwb_bubble,
      output fwd_a, fwd_b, timeout_err, stall_cycles, flush_count, state_o
   );

   modport slave (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_rs1, ex_rs2, ex_rd, ex_regwe, ex_load, ex_redirect,
      output mem_rd, wb_rd, mem_regwe, wb_regwe, mem_req, mem_ack,
      input  pc_hold, ifid_hold, idex_hold, exmem_hold,
      input  ifid_flush, idex_flush, memwb_bubble,
      input  fwd_a, fwd_b, timeout_err, stall_cycles, flush_count, state_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use, redirect and DRAM-wait stalls, EX forwarding,
// post-reset drain, DRAM timeout detection and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int INIT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input logic           clk,
   input logic           rst_n,
   hazard_ctrl_if.master io_hz
);
   localparam logic [1:0] S_INIT     = 2'b00;
   localparam logic [1:0] S_RUN      = 2'b01;
   localparam logic [1:0] S_MEM_WAIT = 2'b10;
   localparam logic [1:0] S_ERROR    = 2'b11;

   localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [IW-1:0]    r_init_cnt;
   logic [WW-1:0]    r_wait_cnt;
   logic             r_timeout_err;
   logic [CNT_W-1:0] r_stall_cycles, r_flush_count;

   logic w_mem_stall, w_load_use, w_active, w_stall_inc, w_flush_inc;
   logic w_pc_hold, w_ifid_hold, w_idex_hold, w_exmem_hold;
   logic w_ifid_flush, w_idex_flush, w_memwb_bubble;
   logic [1:0] w_fwd_a, w_fwd_b;

   assign w_mem_stall = io_hz.mem_req & ~io_hz.mem_ack;
   assign w_load_use  = io_hz.ex_load & io_hz.ex_regwe & (io_hz.ex_rd != 5'd0) &
                        ((io_hz.id_use_rs1 & (io_hz.ex_rd == io_hz.id_rs1)) |
                         (io_hz.id_use_rs2 & (io_hz.ex_rd == io_hz.id_rs2)));
   assign w_active    = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
   assign w_stall_inc = w_active & (w_mem_stall | (w_load_use & ~io_hz.ex_redirect));
   assign w_flush_inc = w_active & ~w_mem_stall & io_hz.ex_redirect;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (io_hz.mem_regwe && io_hz.mem_rd != 5'd0 && io_hz.mem_rd == rs)
         return 2'b01;
      else if (io_hz.wb_regwe && io_hz.wb_rd != 5'd0 && io_hz.wb_rd == rs)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      w_pc_hold      = 1'b0;
      w_ifid_hold    = 1'b0;
      w_idex_hold    = 1'b0;
      w_exmem_hold   = 1'b0;
      w_ifid_flush   = 1'b0;
      w_idex_flush   = 1'b0;
      w_memwb_bubble = 1'b0;
      w_fwd_a        = 2'b00;
      w_fwd_b        = 2'b00;
      case (r_state)
         S_INIT: begin
            w_pc_hold    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
         end
         S_ERROR: begin
            w_pc_hold      = 1'b1;
            w_ifid_hold    = 1'b1;
            w_idex_hold    = 1'b1;
            w_exmem_hold   = 1'b1;
            w_memwb_bubble = 1'b1;
         end
         default: begin
            // A held EX instruction re-presents its redirect/load-use once DRAM completes.
            if (w_mem_stall) begin
               w_pc_hold      = 1'b1;
               w_ifid_hold    = 1'b1;
               w_idex_hold    = 1'b1;
               w_exmem_hold   = 1'b1;
               w_memwb_bubble = 1'b1;
            end else if (io_hz.ex_redirect) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
            end else if (w_load_use) begin
               w_pc_hold    = 1'b1;
               w_ifid_hold  = 1'b1;
               w_idex_flush = 1'b1;
            end
            w_fwd_a = fwd_sel(io_hz.ex_rs1);
            w_fwd_b = fwd_sel(io_hz.ex_rs2);
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_INIT;
         r_init_cnt    <= '0;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (r_init_cnt == INIT_LAST) r_state <= S_RUN;
               else                         r_init_cnt <= r_init_cnt + 1'b1;
            end
            S_RUN: begin
               if (w_mem_stall) begin
                  r_state    <= S_MEM_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            S_MEM_WAIT: begin
               if (!w_mem_stall) begin
                  r_state <= S_RUN;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state       <= S_ERROR;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: r_state <= S_ERROR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_stall_inc && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_flush_inc && r_flush_count  != '1) r_flush_count  <= r_flush_count + 1'b1;
      end
   end

   assign io_hz.pc_hold      = w_pc_hold;
   assign io_hz.ifid_hold    = w_ifid_hold;
   assign io_hz.idex_hold    = w_idex_hold;
   assign io_hz.exmem_hold   = w_exmem_hold;
   assign io_hz.ifid_flush   = w_ifid_flush;
   assign io_hz.idex_flush   = w_idex_flush;
   assign io_hz.memwb_bubble = w_memwb_bubble;
   assign io_hz.fwd_a        = w_fwd_a;
   assign io_hz.fwd_b        = w_fwd_b;
   assign io_hz.timeout_err  = r_timeout_err;
   assign io_hz.stall_cycles = r_stall_cycles;
   assign io_hz.flush_count  = r_flush_count;
   assign io_hz.state_o      = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: drain, load-use, redirect, DRAM wait, forwarding, timeout.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) hz ();

   hazard_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_hz (hz.master)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
      hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0; hz.ex_rd = 5'd0;
      hz.ex_regwe = 1'b0; hz.ex_load = 1'b0; hz.ex_redirect = 1'b0;
      hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.mem_regwe = 1'b0; hz.wb_regwe = 1'b0;
      hz.mem_req = 1'b0; hz.mem_ack = 1'b0;
   endtask

   // Advance one clock and land on the falling edge, where inputs change and outputs settle.
   task automatic next();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Controls packed as {pc,ifid,idex,exmem holds, ifid_flush, idex_flush, memwb_bubble}
   function automatic logic [6:0] ctl();
      return {hz.pc_hold, hz.ifid_hold, hz.idex_hold, hz.exmem_hold,
              hz.ifid_flush, hz.idex_flush, hz.memwb_bubble};
   endfunction

   initial begin
      idle();
      #2;
      check("rst_state", 32'(hz.state_o), 32'd0);
      check("rst_ctl", 32'(ctl()), 32'b1000_110);
      check("rst_cnt", hz.stall_cycles | hz.flush_count, 32'd0);
      check("rst_terr", 32'(hz.timeout_err), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("init_state%0d", i), 32'(hz.state_o), 32'd0);
         check($sformatf("init_ctl%0d", i), 32'(ctl()), 32'b1000_110);
         next();
      end
      #1;
      check("run_state", 32'(hz.state_o), 32'd1);
      check("run_ctl", 32'(ctl()), 32'd0);
      check("run_cnt", hz.stall_cycles | hz.flush_count, 32'd0);

      // Load-use via rs2
      hz.ex_load = 1'b1; hz.ex_regwe = 1'b1; hz.ex_rd = 5'd5;
      hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
      #1 check("lu_ctl", 32'(ctl()), 32'b1100_010);
      next();
      check("lu_stall", hz.stall_cycles, 32'd1);
      hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
      #1 check("lu_rd0_ctl", 32'(ctl()), 32'd0);
      hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
      #1 check("lu_nouse_ctl", 32'(ctl()), 32'd0);
      next();
      check("lu_nostall", hz.stall_cycles, 32'd1);

      // Load-use plus redirect: redirect wins
      hz.id_use_rs1 = 1'b1; hz.ex_redirect = 1'b1;
      #1 check("lu_redir_ctl", 32'(ctl()), 32'b0000_110);
      next();
      check("lu_redir_flush", hz.flush_count, 32'd1);
      check("lu_redir_stall", hz.stall_cycles, 32'd1);
      idle();

      // DRAM wait of 3 cycles with redirect pending, then ack
      hz.mem_req = 1'b1; hz.ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mw_state%0d", i), 32'(hz.state_o), (i == 0) ? 32'd1 : 32'd2);
         check($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'b1111_001);
         next();
      end
      hz.mem_ack = 1'b1;
      #1;
      check("mw_ack_state", 32'(hz.state_o), 32'd2);
      check("mw_ack_ctl", 32'(ctl()), 32'b0000_110);
      next();
      check("mw_back_state", 32'(hz.state_o), 32'd1);
      check("mw_stall", hz.stall_cycles, 32'd4);
      check("mw_flush", hz.flush_count, 32'd2);
      idle();

      // req and ack together in RUN: no stall
      hz.mem_req = 1'b1; hz.mem_ack = 1'b1;
      #1 check("reqack_ctl", 32'(ctl()), 32'd0);
      next();
      check("reqack_state", 32'(hz.state_o), 32'd1);
      check("reqack_stall", hz.stall_cycles, 32'd4);

      // req drops during MEM_WAIT without ack
      hz.mem_ack = 1'b0;
      next();
      check("drop_wait", 32'(hz.state_o), 32'd2);
      hz.mem_req = 1'b0;
      #1 check("drop_ctl", 32'(ctl()), 32'd0);
      next();
      check("drop_state", 32'(hz.state_o), 32'd1);
      check("drop_stall", hz.stall_cycles, 32'd5);

      // Forwarding
      hz.ex_rs1 = 5'd3; hz.mem_rd = 5'd3; hz.wb_rd = 5'd3;
      hz.mem_regwe = 1'b1; hz.wb_regwe = 1'b1;
      #1 check("fwd_a_mem", 32'(hz.fwd_a), 32'd1);
      hz.mem_regwe = 1'b0;
      #1 check("fwd_a_wb", 32'(hz.fwd_a), 32'd2);
      hz.ex_rs1 = 5'd0; hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.mem_regwe = 1'b1;
      #1 check("fwd_a_x0", 32'(hz.fwd_a), 32'd0);
      hz.ex_rs2 = 5'd9; hz.wb_rd = 5'd9; hz.mem_rd = 5'd4;
      #1 check("fwd_b_wb", 32'(hz.fwd_b), 32'd2);
      hz.mem_rd = 5'd9;
      #1 check("fwd_b_mem", 32'(hz.fwd_b), 32'd1);
      next();
      idle();

      // Timeout: one RUN stall cycle, then 8 MEM_WAIT cycles, then ERROR
      hz.mem_req = 1'b1;
      #1 check("to_run", 32'(hz.state_o), 32'd1);
      next();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("to_wait%0d", i), 32'(hz.state_o), 32'd2);
         next();
      end
      hz.ex_rs1 = 5'd3; hz.mem_rd = 5'd3; hz.mem_regwe = 1'b1;
      #1;
      check("err_state", 32'(hz.state_o), 32'd3);
      check("err_terr", 32'(hz.timeout_err), 32'd1);
      check("err_ctl", 32'(ctl()), 32'b1111_001);
      check("err_fwd", 32'(hz.fwd_a), 32'd0);
      check("err_stall", hz.stall_cycles, 32'd14);
      hz.mem_req = 1'b0; hz.mem_ack = 1'b1; hz.ex_redirect = 1'b1;
      next();
      next();
      check("err_sticky", 32'({hz.state_o, hz.timeout_err}), 32'b111);
      check("err_frozen", hz.stall_cycles + hz.flush_count, 32'd16);

      // Asynchronous reset out of ERROR
      rst_n = 1'b0;
      #1;
      check("rerst_state", 32'(hz.state_o), 32'd0);
      check("rerst_terr", 32'(hz.timeout_err), 32'd0);
      check("rerst_ctl", 32'(ctl()), 32'b1000_110);
      #10 rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
